pkmc_sdram_responder: RTL

Synthesizable SDR SDRAM device responder: the far end of the pkmc SDRAM command interface. It decodes CS/RAS/CAS/WE commands, tracks the init sequence and per-bank open rows, and serves single-word reads and writes from an internal array with programmable CAS latency. It flags protocol violations. It sits in the dafk testbench and FPGA self-test builds in place of the external SDRAM chip, driven by the pkmc SDRAM controller.

---
 rtl/pkmc_sdram_responder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pkmc_sdram_responder.sv
// SDR SDRAM device model for controller bring-up: decodes commands, tracks the init
// sequence and open rows, and serves single-word reads/writes with CAS latency 2 or 3.
module pkmc_sdram_responder #(
  parameter int DATA_W = 32,
  parameter int BANK_W = 2,
  parameter int ROW_W  = 4,
  parameter int COL_W  = 4,
  parameter int ADDR_W = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cke,
  input  logic                cs_n,
  input  logic                ras_n,
  input  logic                cas_n,
  input  logic                we_n,
  input  logic [BANK_W-1:0]   ba,
  input  logic [ADDR_W-1:0]   a,
  input  logic [DATA_W/8-1:0] dqm,
  input  logic [DATA_W-1:0]   dq_i,
  output logic [DATA_W-1:0]   dq_o,
  output logic                dq_oe,
  output logic                init_done,
  output logic                prot_err,
  output logic [2:0]          err_code,
  output logic [15:0]         refresh_cnt
);

  localparam int NB    = DATA_W / 8;
  localparam int NBANK = 1 << BANK_W;
  localparam int IDX_W = BANK_W + ROW_W + COL_W;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [2:0] ST_UNINIT     = 3'd0;
  localparam logic [2:0] ST_PRECHARGED = 3'd1;
  localparam logic [2:0] ST_REF1       = 3'd2;
  localparam logic [2:0] ST_REF2       = 3'd3;
  localparam logic [2:0] ST_READY      = 3'd4;

  localparam logic [2:0] ERR_BANK_OPEN   = 3'd1;
  localparam logic [2:0] ERR_BANK_CLOSED = 3'd2;
  localparam logic [2:0] ERR_NOT_READY   = 3'd3;
  localparam logic [2:0] ERR_REF_OPEN    = 3'd4;
  localparam logic [2:0] ERR_MODE_OPEN   = 3'd5;
  localparam logic [2:0] ERR_MODE_BAD    = 3'd6;
  localparam logic [2:0] ERR_WR_BUSY     = 3'd7;

  logic [2:0]        state_q, state_d;
  logic              bank_open_q [NBANK];
  logic [ROW_W-1:0]  open_row_q [NBANK];
  logic              cl3_q, cl3_pend_q;
  logic [15:0]       refresh_cnt_q;
  logic              prot_err_q;
  logic [2:0]        err_code_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_masked, d2_q, dq_o_q;
  logic [NB-1:0]     m1_q;
  logic              v1_q, v2_q, dq_oe_q;

  logic              cmd_vld, is_act, is_rd, is_wr, is_pre, is_ref, is_mrs;
  logic              any_open, cur_open, ready, mode_ok;
  logic [2:0]        err_d;
  logic              act_ok, rd_ok, wr_ok, ref_ok, mrs_ok;
  logic [IDX_W-1:0]  idx;
  logic              unused_a;

  assign cmd_vld = cke && !rst && !cs_n;
  assign is_act  = cmd_vld && ({ras_n, cas_n, we_n} == 3'b011);
  assign is_rd   = cmd_vld && ({ras_n, cas_n, we_n} == 3'b101);
  assign is_wr   = cmd_vld && ({ras_n, cas_n, we_n} == 3'b100);
  assign is_pre  = cmd_vld && ({ras_n, cas_n, we_n} == 3'b010);
  assign is_ref  = cmd_vld && ({ras_n, cas_n, we_n} == 3'b001);
  assign is_mrs  = cmd_vld && ({ras_n, cas_n, we_n} == 3'b000);

  assign ready    = (state_q == ST_READY);
  assign cur_open = bank_open_q[ba];
  assign mode_ok  = ((a[6:4] == 3'd2) || (a[6:4] == 3'd3)) && (a[2:0] == 3'd0);
  assign idx      = {ba, open_row_q[ba], a[COL_W-1:0]};
  assign unused_a = ^a;

  always_comb begin
    any_open = 1'b0;
    for (int i = 0; i < NBANK; i++) any_open = any_open | bank_open_q[i];
  end

  // Each command yields at most one error code; a non-zero code suppresses execution.
  always_comb begin
    err_d = 3'd0;
    if (is_act) begin
      if (!ready)        err_d = ERR_NOT_READY;
      else if (cur_open) err_d = ERR_BANK_OPEN;
    end else if (is_rd || is_wr) begin
      if (!ready)                err_d = ERR_NOT_READY;
      else if (!cur_open)        err_d = ERR_BANK_CLOSED;
      else if (is_wr && dq_oe_q) err_d = ERR_WR_BUSY;
    end else if (is_ref) begin
      if (any_open) err_d = ERR_REF_OPEN;
    end else if (is_mrs) begin
      if (!mode_ok)      err_d = ERR_MODE_BAD;
      else if (any_open) err_d = ERR_MODE_OPEN;
    end
  end

  assign act_ok = is_act && (err_d == 3'd0);
  assign rd_ok  = is_rd  && (err_d == 3'd0);
  assign wr_ok  = is_wr  && (err_d == 3'd0);
  assign ref_ok = is_ref && (err_d == 3'd0);
  assign mrs_ok = is_mrs && (err_d == 3'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNINIT:     if (is_pre && a[10]) state_d = ST_PRECHARGED;
      ST_PRECHARGED: if (ref_ok)          state_d = ST_REF1;
      ST_REF1:       if (ref_ok)          state_d = ST_REF2;
      ST_REF2:       if (mrs_ok)          state_d = ST_READY;
      default:       state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_UNINIT;
      cl3_pend_q    <= 1'b0;
      refresh_cnt_q <= 16'd0;
      prot_err_q    <= 1'b0;
      err_code_q    <= 3'd0;
      for (int i = 0; i < NBANK; i++) bank_open_q[i] <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mrs_ok) cl3_pend_q <= (a[6:4] == 3'd3);
      if (ref_ok) refresh_cnt_q <= refresh_cnt_q + 16'd1;
      if (err_d != 3'd0) begin
        prot_err_q <= 1'b1;
        if (!prot_err_q) err_code_q <= err_d;
      end
      for (int i = 0; i < NBANK; i++) begin
        if (act_ok && (ba == BANK_W'(i))) begin
          bank_open_q[i] <= 1'b1;
          open_row_q[i]  <= a[ROW_W-1:0];
        end else if (is_pre && (a[10] || (ba == BANK_W'(i)))) begin
          bank_open_q[i] <= 1'b0;
        end
      end
    end
  end

  // Storage array: byte-lane writes, registered read feeding the latency pipeline.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (!dqm[b]) mem[idx][b*8 +: 8] <= dq_i[b*8 +: 8];
      end
    end
    if (rd_ok) rd_data_q <= mem[idx];
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign rd_data_masked[gi*8 +: 8] = m1_q[gi] ? 8'h00 : rd_data_q[gi*8 +: 8];
    end
  endgenerate

  // Stage 1 is the array read; CL3 inserts stage 2 before the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      dq_oe_q <= 1'b0;
      dq_o_q  <= '0;
      cl3_q   <= 1'b0;
    end else if (cke) begin
      v1_q <= rd_ok;
      m1_q <= dqm;
      v2_q <= v1_q && cl3_q;
      d2_q <= rd_data_masked;
      if (cl3_q) begin
        dq_oe_q <= v2_q;
        dq_o_q  <= v2_q ? d2_q : '0;
      end else begin
        dq_oe_q <= v1_q;
        dq_o_q  <= v1_q ? rd_data_masked : '0;
      end
      if (!v1_q && !v2_q) cl3_q <= cl3_pend_q;
    end
  end

  assign dq_o        = dq_o_q;
  assign dq_oe       = dq_oe_q;
  assign init_done   = ready;
  assign prot_err    = prot_err_q;
  assign err_code    = err_code_q;
  assign refresh_cnt = refresh_cnt_q;

endmodule
